// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory bank.
// It takes a byte stream on a valid/ready handshake. The stream is one header
// byte N, then 4*N data bytes, then one XOR checksum byte.
// Data bytes are packed big-endian into 32-bit words and written to word-aligned
// addresses starting at 0.
// The CPU is held stalled until an image with a good checksum has been loaded.
module imem_loader #(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 2 ** (ADDR_W - 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] word_count
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HDR   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_CHK   = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERR   = 3'd6;

  localparam logic [ADDR_W-2:0] WC_ONE = {{(ADDR_W-2){1'b0}}, 1'b1};

  // Running checksum fold: XOR of every header and data byte seen so far.
  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [ADDR_W-2:0] n_r;
  logic [ADDR_W-2:0] word_count_r;
  logic [ADDR_W-2:0] wc_inc_s;
  logic [1:0]        byte_idx_r;
  logic [23:0]       shift_r;
  logic [7:0]        csum_r;
  logic [ADDR_W-1:0] imem_addr_r;
  logic [31:0]       imem_wdata_r;
  logic              byte_ready_s;
  logic              xfer_s;
  logic              hdr_too_big_s;

  // byte_ready is a pure state decode, so byte_valid never feeds back into it.
  assign byte_ready_s  = (state_r == ST_HDR) || (state_r == ST_DATA) || (state_r == ST_CHK);
  assign xfer_s        = byte_valid & byte_ready_s;
  assign hdr_too_big_s = ({24'd0, byte_in} > 32'(MAX_WORDS));
  assign wc_inc_s      = word_count_r + WC_ONE;

  assign byte_ready = byte_ready_s;
  assign imem_we    = (state_r == ST_WRITE);
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = (state_r != ST_DONE);
  assign done       = (state_r == ST_DONE);
  assign error      = (state_r == ST_ERR);
  assign word_count = word_count_r;

  // Next-state selection for the load sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_HDR;
        else       state_nxt_s = ST_IDLE;
      end
      ST_HDR: begin
        if (!xfer_s)               state_nxt_s = ST_HDR;
        else if (hdr_too_big_s)    state_nxt_s = ST_ERR;
        else if (byte_in == 8'd0)  state_nxt_s = ST_CHK;
        else                       state_nxt_s = ST_DATA;
      end
      ST_DATA: begin
        if (xfer_s && (byte_idx_r == 2'd3)) state_nxt_s = ST_WRITE;
        else                                state_nxt_s = ST_DATA;
      end
      ST_WRITE: begin
        if (wc_inc_s == n_r) state_nxt_s = ST_CHK;
        else                 state_nxt_s = ST_DATA;
      end
      ST_CHK: begin
        if (!xfer_s)                 state_nxt_s = ST_CHK;
        else if (byte_in == csum_r)  state_nxt_s = ST_DONE;
        else                         state_nxt_s = ST_ERR;
      end
      ST_DONE: begin
        if (start) state_nxt_s = ST_HDR;
        else       state_nxt_s = ST_DONE;
      end
      ST_ERR: begin
        if (start) state_nxt_s = ST_HDR;
        else       state_nxt_s = ST_ERR;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register plus datapath: header latch, word assembly, checksum and write address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      n_r          <= '0;
      word_count_r <= '0;
      byte_idx_r   <= 2'd0;
      shift_r      <= 24'd0;
      csum_r       <= 8'd0;
      imem_addr_r  <= '0;
      imem_wdata_r <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        ST_HDR: begin
          if (xfer_s) begin
            n_r          <= (ADDR_W-1)'(byte_in);
            csum_r       <= byte_in;
            word_count_r <= '0;
            byte_idx_r   <= 2'd0;
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            shift_r    <= {shift_r[15:0], byte_in};
            csum_r     <= csum_fold(csum_r, byte_in);
            byte_idx_r <= byte_idx_r + 2'd1;
            // The 4th byte completes the word; stage it and its address for the write cycle.
            if (byte_idx_r == 2'd3) begin
              imem_wdata_r <= {shift_r, byte_in};
              imem_addr_r  <= {word_count_r[ADDR_W-3:0], 2'b00};
            end
          end
        end
        ST_WRITE: begin
          word_count_r <= wc_inc_s;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader.
// Images are random, and the scoreboard derives the expected writes and the
// final status directly from the stream format.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [6:0]  word_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] img_words [64];
  logic [31:0] mem_model [64];
  logic [7:0]  wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error),
    .word_count(word_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Instruction memory stand-in plus write log; also checks that no byte is offered during a write.
  always @(negedge clk) begin
    if (!rst && imem_we) begin
      wr_addr_q.push_back(imem_addr);
      wr_data_q.push_back(imem_wdata);
      mem_model[imem_addr[7:2]] = imem_wdata;
      check_eq("ready_during_write", 32'(byte_ready), 32'd0);
    end
  end

  task automatic pulse_start();
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    n = 0;
    if (gaps) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check_eq("handshake_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_vals();
    check_eq("rst_byte_ready", 32'(byte_ready), 32'd0);
    check_eq("rst_imem_we", 32'(imem_we), 32'd0);
    check_eq("rst_imem_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_imem_wdata", imem_wdata, 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_error", 32'(error), 32'd0);
    check_eq("rst_word_count", 32'(word_count), 32'd0);
    check_eq("rst_cpu_hold", 32'(cpu_hold), 32'd1);
  endtask

  task automatic idle_valid_check();
    byte_in = 8'hA5;
    byte_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("idle_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
  endtask

  // One complete load of img_words[0..n-1]; checks writes and final status against the stream rules.
  task automatic run_load(input logic [7:0] n, input bit bad_cs, input bit gaps, input bit mid_start);
    logic [7:0] cs;
    logic [7:0] v;
    int exp_wr;
    bit exp_ok;
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    cs = n;
    send_byte(n, gaps);
    if (n <= 8'd64) begin
      for (int w = 0; w < int'(n); w++) begin
        for (int b = 0; b < 4; b++) begin
          v = img_words[w][31 - 8*b -: 8];
          cs = cs ^ v;
          send_byte(v, gaps);
          if (mid_start && w == 0 && b == 1) pulse_start();
        end
      end
      send_byte(bad_cs ? (cs ^ 8'h01) : cs, gaps);
    end
    byte_valid = 1'b0;
    exp_wr = (n <= 8'd64) ? int'(n) : 0;
    exp_ok = (n <= 8'd64) && !bad_cs;
    check_eq("done", 32'(done), 32'(exp_ok));
    check_eq("error", 32'(error), 32'(!exp_ok));
    check_eq("cpu_hold", 32'(cpu_hold), 32'(!exp_ok));
    check_eq("word_count", 32'(word_count), 32'(exp_wr));
    check_eq("write_count", 32'(wr_addr_q.size()), 32'(exp_wr));
    for (int i = 0; i < exp_wr && i < wr_addr_q.size(); i++) begin
      check_eq("write_addr", 32'(wr_addr_q[i]), 32'(i * 4));
      check_eq("write_data", wr_data_q[i], img_words[i]);
    end
    repeat (2) @(negedge clk);
    check_eq("no_extra_writes", 32'(wr_addr_q.size()), 32'(exp_wr));
  endtask

  task automatic randomize_image();
    for (int i = 0; i < 64; i++) img_words[i] = $urandom();
  endtask

  // Reset asserted while the 3rd byte of word 1 of a 4-word image is on the bus.
  task automatic reset_mid_load();
    logic [7:0] v;
    randomize_image();
    wr_addr_q.delete();
    wr_data_q.delete();
    pulse_start();
    send_byte(8'd4, 1'b0);
    for (int b = 0; b < 6; b++) begin
      v = (b < 4) ? img_words[0][31 - 8*b -: 8] : img_words[1][31 - 8*(b-4) -: 8];
      send_byte(v, 1'b0);
    end
    byte_in = img_words[1][15:8];
    byte_valid = 1'b1;
    #2 rst = 1'b1;
    #1 check_reset_vals();
    byte_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid_writes", 32'(wr_addr_q.size()), 32'd1);
    check_eq("rst_mid_word0_kept", mem_model[0], img_words[0]);
    idle_valid_check();
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] n;
    bit bad;
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b0;
    @(negedge clk);
    idle_valid_check();

    // Directed two-word image, good then corrupted checksum, then recovery.
    img_words[0] = 32'h12345678;
    img_words[1] = 32'hDEADBEEF;
    run_load(8'd2, 1'b0, 1'b0, 1'b0);
    run_load(8'd2, 1'b1, 1'b0, 1'b0);
    randomize_image();
    run_load(8'd3, 1'b0, 1'b1, 1'b0);

    // Length boundaries: one past capacity, and an empty image.
    run_load(8'h41, 1'b0, 1'b0, 1'b0);
    run_load(8'h00, 1'b0, 1'b0, 1'b0);

    // Full-capacity image with random valid gaps.
    randomize_image();
    run_load(8'd64, 1'b0, 1'b1, 1'b0);

    // Start pulsed in the middle of a word must be ignored.
    randomize_image();
    run_load(8'd5, 1'b0, 1'b0, 1'b1);

    // Random images, lengths and checksum corruption.
    for (int k = 0; k < 8; k++) begin
      randomize_image();
      n = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(65, 255)) : 8'($urandom_range(0, 64));
      bad = ($urandom_range(0, 3) == 0);
      run_load(n, bad, 1'b1, bit'($urandom_range(0, 1)));
    end

    reset_mid_load();
    randomize_image();
    run_load(8'd4, 1'b0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
